// File: rtl/xphy_training_arb.sv
// ---------------------------------------------------------------------------
// xphy_training_arb
// Arbitrates two requesters (req0 = host register bridge, req1 = link bring-up
// sequencer) onto the PCS/PMA training/management port. One access in flight
// at a time. Each access is bounded by a timeout, and a timeout is returned
// as an error.
//
// Ports
//   clk156, reset                 core clock, async active-high reset
//   reqN_valid/addr/rnw/wrdata/drp request from requester N (held until ack)
//   reqN_ack/rddata/err           one-cycle completion pulse with response
//   training_enable/addr/rnw/wrdata/ipif_cs/drp_cs   PHY-side request
//   training_rddata/rdack/wrack   PHY-side response
// ---------------------------------------------------------------------------
module xphy_training_arb #(
  parameter int unsigned C_TIMEOUT = 1023,
  parameter int unsigned C_RR      = 1
) (
  input  logic        clk156,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [20:0] req0_addr,
  input  logic        req0_rnw,
  input  logic [15:0] req0_wrdata,
  input  logic        req0_drp,
  output logic        req0_ack,
  output logic [15:0] req0_rddata,
  output logic        req0_err,
  input  logic        req1_valid,
  input  logic [20:0] req1_addr,
  input  logic        req1_rnw,
  input  logic [15:0] req1_wrdata,
  input  logic        req1_drp,
  output logic        req1_ack,
  output logic [15:0] req1_rddata,
  output logic        req1_err,
  output logic        training_enable,
  output logic [20:0] training_addr,
  output logic        training_rnw,
  output logic [15:0] training_wrdata,
  output logic        training_ipif_cs,
  output logic        training_drp_cs,
  input  logic [15:0] training_rddata,
  input  logic        training_rdack,
  input  logic        training_wrack
);

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              r_state,      w_state;
  logic [CNT_W-1:0]    r_cnt,        w_cnt;
  logic                r_last_grant, w_last_grant;
  logic                r_grant,      w_grant;
  logic [ADDR_W-1:0]   r_addr,       w_addr;
  logic                r_rnw,        w_rnw;
  logic [DATA_W-1:0]   r_wrdata,     w_wrdata;
  logic                r_drp,        w_drp;
  logic                r_enable,     w_enable;
  logic                r_ipif_cs,    w_ipif_cs;
  logic                r_drp_cs,     w_drp_cs;
  logic                r_ack0,       w_ack0;
  logic                r_ack1,       w_ack1;
  logic [DATA_W-1:0]   r_rsp_data,   w_rsp_data;
  logic                r_rsp_err,    w_rsp_err;

  logic w_pick;
  logic w_complete;

  // Winner when leaving IDLE: alternate on contention in round-robin mode,
  // otherwise req0 has priority; a lone requester always wins.
  assign w_pick = (req0_valid && req1_valid) ? ((C_RR != 0) ? ~r_last_grant : 1'b0)
                                             : req1_valid;

  // Only the acknowledge matching the latched direction completes an access.
  assign w_complete = r_rnw ? training_rdack : training_wrack;

  // State and output registers.
  always_ff @(posedge clk156 or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_addr       <= '0;
      r_rnw        <= 1'b1;
      r_wrdata     <= '0;
      r_drp        <= 1'b0;
      r_enable     <= 1'b0;
      r_ipif_cs    <= 1'b0;
      r_drp_cs     <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_last_grant <= w_last_grant;
      r_grant      <= w_grant;
      r_addr       <= w_addr;
      r_rnw        <= w_rnw;
      r_wrdata     <= w_wrdata;
      r_drp        <= w_drp;
      r_enable     <= w_enable;
      r_ipif_cs    <= w_ipif_cs;
      r_drp_cs     <= w_drp_cs;
      r_ack0       <= w_ack0;
      r_ack1       <= w_ack1;
      r_rsp_data   <= w_rsp_data;
      r_rsp_err    <= w_rsp_err;
    end
  end

  // Next-state and next-output logic. The PHY-side strobes and the response
  // are updated on the WAIT->DONE transition so the ack is visible during DONE.
  always_comb begin
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_last_grant = r_last_grant;
    w_grant      = r_grant;
    w_addr       = r_addr;
    w_rnw        = r_rnw;
    w_wrdata     = r_wrdata;
    w_drp        = r_drp;
    w_enable     = r_enable;
    w_ipif_cs    = r_ipif_cs;
    w_drp_cs     = r_drp_cs;
    w_ack0       = 1'b0;
    w_ack1       = 1'b0;
    w_rsp_data   = r_rsp_data;
    w_rsp_err    = r_rsp_err;

    case (r_state)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          w_grant      = w_pick;
          w_last_grant = w_pick;
          w_addr       = w_pick ? req1_addr   : req0_addr;
          w_rnw        = w_pick ? req1_rnw    : req0_rnw;
          w_wrdata     = w_pick ? req1_wrdata : req0_wrdata;
          w_drp        = w_pick ? req1_drp    : req0_drp;
          w_state      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_enable  = 1'b1;
        w_ipif_cs = ~r_drp;
        w_drp_cs  = r_drp;
        w_cnt     = '0;
        w_state   = S_WAIT;
      end
      S_WAIT: begin
        if (w_complete || (r_cnt == CNT_W'(C_TIMEOUT))) begin
          // Completion takes precedence over a coincident timeout.
          w_rsp_err  = ~w_complete;
          w_rsp_data = !w_complete ? 16'hFFFF : (r_rnw ? training_rddata : '0);
          w_enable   = 1'b0;
          w_ipif_cs  = 1'b0;
          w_drp_cs   = 1'b0;
          w_ack0     = ~r_grant;
          w_ack1     = r_grant;
          w_state    = S_DONE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  assign req0_ack         = r_ack0;
  assign req1_ack         = r_ack1;
  assign req0_rddata      = r_rsp_data;
  assign req1_rddata      = r_rsp_data;
  assign req0_err         = r_rsp_err;
  assign req1_err         = r_rsp_err;
  assign training_enable  = r_enable;
  assign training_addr    = r_addr;
  assign training_rnw     = r_rnw;
  assign training_wrdata  = r_wrdata;
  assign training_ipif_cs = r_ipif_cs;
  assign training_drp_cs  = r_drp_cs;

endmodule

// File: tb/tb_xphy_training_arb.sv
// ---------------------------------------------------------------------------
// tb_xphy_training_arb
// Self-checking bench: a round-robin instance driven by a configurable PHY
// model with a response scoreboard, plus a fixed-priority instance with an
// always-ready PHY for the priority check.
// ---------------------------------------------------------------------------
module tb_xphy_training_arb;

  localparam int unsigned TO = 1023;

  logic clk156 = 1'b0;
  logic reset;
  always #5 clk156 = ~clk156;

  // ---------------- round-robin instance ----------------
  logic        req0_valid, req0_rnw, req0_drp, req0_ack, req0_err;
  logic [20:0] req0_addr;
  logic [15:0] req0_wrdata, req0_rddata;
  logic        req1_valid, req1_rnw, req1_drp, req1_ack, req1_err;
  logic [20:0] req1_addr;
  logic [15:0] req1_wrdata, req1_rddata;
  logic        training_enable, training_rnw, training_ipif_cs, training_drp_cs;
  logic [20:0] training_addr;
  logic [15:0] training_wrdata, training_rddata;
  logic        training_rdack, training_wrack;

  xphy_training_arb #(.C_TIMEOUT(TO), .C_RR(1)) u_dut (
    .clk156(clk156), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_rnw(req0_rnw),
    .req0_wrdata(req0_wrdata), .req0_drp(req0_drp), .req0_ack(req0_ack),
    .req0_rddata(req0_rddata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_rnw(req1_rnw),
    .req1_wrdata(req1_wrdata), .req1_drp(req1_drp), .req1_ack(req1_ack),
    .req1_rddata(req1_rddata), .req1_err(req1_err),
    .training_enable(training_enable), .training_addr(training_addr),
    .training_rnw(training_rnw), .training_wrdata(training_wrdata),
    .training_ipif_cs(training_ipif_cs), .training_drp_cs(training_drp_cs),
    .training_rddata(training_rddata), .training_rdack(training_rdack),
    .training_wrack(training_wrack)
  );

  // PHY model: acks phy_lat cycles after the first cs cycle.
  logic        phy_rdack = 1'b0;
  logic        phy_wrack = 1'b0;
  logic        stray;
  int          phy_cnt = 0;
  int          phy_lat;
  bit          phy_never, phy_wrong;
  logic [15:0] phy_xor;

  assign training_rddata = training_addr[15:0] ^ phy_xor;
  assign training_rdack  = phy_rdack | stray;
  assign training_wrack  = phy_wrack | stray;

  always @(posedge clk156) begin
    #1;
    phy_rdack = 1'b0;
    phy_wrack = 1'b0;
    if (training_enable) phy_cnt++;
    else phy_cnt = 0;
    if (training_enable && !phy_never) begin
      if (phy_wrong && phy_cnt == 2) begin
        if (training_rnw) phy_wrack = 1'b1;
        else phy_rdack = 1'b1;
      end
      if (phy_cnt == phy_lat + 1) begin
        if (training_rnw) phy_rdack = 1'b1;
        else phy_wrack = 1'b1;
      end
    end
  end

  // ---------------- fixed-priority instance ----------------
  logic        f_req0_valid, f_req0_ack, f_req0_err;
  logic [20:0] f_req0_addr;
  logic [15:0] f_req0_rddata;
  logic        f_req1_valid, f_req1_ack, f_req1_err;
  logic [20:0] f_req1_addr;
  logic [15:0] f_req1_rddata;
  logic        f_enable, f_rnw, f_ipif_cs, f_drp_cs;
  logic [20:0] f_addr;
  logic [15:0] f_wrdata, f_rddata;
  logic        f_rdack = 1'b0;
  logic        f_wrack = 1'b0;

  xphy_training_arb #(.C_TIMEOUT(TO), .C_RR(0)) u_dut_fp (
    .clk156(clk156), .reset(reset),
    .req0_valid(f_req0_valid), .req0_addr(f_req0_addr), .req0_rnw(1'b1),
    .req0_wrdata(16'h0000), .req0_drp(1'b0), .req0_ack(f_req0_ack),
    .req0_rddata(f_req0_rddata), .req0_err(f_req0_err),
    .req1_valid(f_req1_valid), .req1_addr(f_req1_addr), .req1_rnw(1'b1),
    .req1_wrdata(16'h0000), .req1_drp(1'b0), .req1_ack(f_req1_ack),
    .req1_rddata(f_req1_rddata), .req1_err(f_req1_err),
    .training_enable(f_enable), .training_addr(f_addr),
    .training_rnw(f_rnw), .training_wrdata(f_wrdata),
    .training_ipif_cs(f_ipif_cs), .training_drp_cs(f_drp_cs),
    .training_rddata(f_rddata), .training_rdack(f_rdack),
    .training_wrack(f_wrack)
  );

  assign f_rddata = f_addr[15:0];

  always @(posedge clk156) begin
    #1;
    f_rdack = f_enable & f_rnw;
    f_wrack = f_enable & ~f_rnw;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        who;
    logic [15:0] rd;
    logic        err;
    int          ipif_n;
    int          drp_n;
    logic [20:0] addr;
    logic        rnw;
    logic [15:0] wd;
  } exp_t;

  typedef struct {
    logic        who;
    logic [15:0] rd;
  } fexp_t;

  exp_t  sb_q[$];
  fexp_t fq[$];
  exp_t  mon_e;
  fexp_t mon_f;
  int    cnt_ipif = 0;
  int    cnt_drp  = 0;
  logic  cs_bad   = 1'b0;

  // Scoreboard monitor for the round-robin instance.
  always @(negedge clk156) begin
    if (reset) begin
      cnt_ipif = 0;
      cnt_drp  = 0;
      cs_bad   = 1'b0;
    end else begin
      if (training_ipif_cs) cnt_ipif++;
      if (training_drp_cs)  cnt_drp++;
      if ((training_ipif_cs && training_drp_cs) ||
          (training_enable != (training_ipif_cs || training_drp_cs))) cs_bad = 1'b1;
      if (req0_ack || req1_ack) begin
        check("ack_exclusive", 32'(req0_ack && req1_ack), 32'd0);
        check("ack_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("grant_who", 32'(req1_ack), 32'(mon_e.who));
          check("rsp_data", 32'(mon_e.who ? req1_rddata : req0_rddata), 32'(mon_e.rd));
          check("rsp_err", 32'(mon_e.who ? req1_err : req0_err), 32'(mon_e.err));
          check("ipif_cycles", 32'(cnt_ipif), 32'(mon_e.ipif_n));
          check("drp_cycles", 32'(cnt_drp), 32'(mon_e.drp_n));
          check("phy_addr", 32'(training_addr), 32'(mon_e.addr));
          check("phy_rnw", 32'(training_rnw), 32'(mon_e.rnw));
          check("phy_wrdata", 32'(training_wrdata), 32'(mon_e.wd));
          check("cs_onehot", 32'(cs_bad), 32'd0);
        end
        cnt_ipif = 0;
        cnt_drp  = 0;
        cs_bad   = 1'b0;
      end
    end
  end

  // Scoreboard monitor for the fixed-priority instance.
  always @(negedge clk156) begin
    if (!reset && (f_req0_ack || f_req1_ack)) begin
      check("fp_ack_exclusive", 32'(f_req0_ack && f_req1_ack), 32'd0);
      check("fp_ack_expected", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) begin
        mon_f = fq.pop_front();
        check("fp_grant_who", 32'(f_req1_ack), 32'(mon_f.who));
        check("fp_rsp_data", 32'(f_req1_ack ? f_req1_rddata : f_req0_rddata), 32'(mon_f.rd));
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_enable"}, 32'(training_enable), 32'd0);
    check({tag, "_addr"},   32'(training_addr),   32'd0);
    check({tag, "_rnw"},    32'(training_rnw),    32'd1);
    check({tag, "_wrdata"}, 32'(training_wrdata), 32'd0);
    check({tag, "_ipif"},   32'(training_ipif_cs), 32'd0);
    check({tag, "_drp"},    32'(training_drp_cs), 32'd0);
    check({tag, "_ack0"},   32'(req0_ack),        32'd0);
    check({tag, "_ack1"},   32'(req1_ack),        32'd0);
    check({tag, "_rd0"},    32'(req0_rddata),     32'd0);
    check({tag, "_rd1"},    32'(req1_rddata),     32'd0);
    check({tag, "_err0"},   32'(req0_err),        32'd0);
    check({tag, "_err1"},   32'(req1_err),        32'd0);
  endtask

  task automatic push_a(input logic who, input logic [20:0] a, input logic rnw,
                        input logic [15:0] wd, input logic drp, input bit tmo, input int lat);
    exp_t e;
    int   ncs;
    e.who    = who;
    e.addr   = a;
    e.rnw    = rnw;
    e.wd     = wd;
    e.err    = tmo;
    e.rd     = tmo ? 16'hFFFF : (rnw ? (a[15:0] ^ phy_xor) : 16'h0000);
    ncs      = tmo ? int'(TO) + 1 : lat + 1;
    e.ipif_n = drp ? 0 : ncs;
    e.drp_n  = drp ? ncs : 0;
    sb_q.push_back(e);
  endtask

  task automatic req_a(input logic n, input logic [20:0] a, input logic rnw,
                       input logic [15:0] wd, input logic drp);
    int t;
    bit seen;
    if (n) begin
      req1_addr = a; req1_rnw = rnw; req1_wrdata = wd; req1_drp = drp; req1_valid = 1'b1;
    end else begin
      req0_addr = a; req0_rnw = rnw; req0_wrdata = wd; req0_drp = drp; req0_valid = 1'b1;
    end
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 3000) begin
      @(negedge clk156);
      seen = n ? req1_ack : req0_ack;
      t++;
    end
    check("req_completed", 32'(seen), 32'd1);
    @(posedge clk156);
    #1;
    if (n) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic xact(input logic who, input logic [20:0] a, input logic rnw,
                      input logic [15:0] wd, input logic drp, input bit tmo, input int lat);
    phy_lat = lat;
    push_a(who, a, rnw, wd, drp, tmo, lat);
    req_a(who, a, rnw, wd, drp);
  endtask

  task automatic req_b(input logic n, input logic [20:0] a);
    int t;
    bit seen;
    if (n) begin f_req1_addr = a; f_req1_valid = 1'b1; end
    else begin f_req0_addr = a; f_req0_valid = 1'b1; end
    t    = 0;
    seen = 1'b0;
    while (!seen && t < 200) begin
      @(negedge clk156);
      seen = n ? f_req1_ack : f_req0_ack;
      t++;
    end
    check("fp_req_completed", 32'(seen), 32'd1);
    @(posedge clk156);
    #1;
    if (n) f_req1_valid = 1'b0;
    else f_req0_valid = 1'b0;
  endtask

  task automatic push_b(input logic who, input logic [20:0] a);
    fexp_t f;
    f.who = who;
    f.rd  = a[15:0];
    fq.push_back(f);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    stray = 1'b0;
    phy_lat = 1; phy_never = 1'b0; phy_wrong = 1'b0; phy_xor = 16'h1235;
    req0_valid = 1'b0; req0_addr = '0; req0_rnw = 1'b1; req0_wrdata = '0; req0_drp = 1'b0;
    req1_valid = 1'b0; req1_addr = '0; req1_rnw = 1'b1; req1_wrdata = '0; req1_drp = 1'b0;
    f_req0_valid = 1'b0; f_req0_addr = '0;
    f_req1_valid = 1'b0; f_req1_addr = '0;
    repeat (3) @(posedge clk156);
    @(negedge clk156);
    check_reset_vals("rst");
    @(posedge clk156);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk156);
    #1;

    // Basic read (rdack 3 cycles after cs) and IPIF write.
    xact(1'b0, 21'h00_0001, 1'b1, 16'h0000, 1'b0, 1'b0, 3);
    xact(1'b1, 21'h1A_BCDE, 1'b0, 16'hBEEF, 1'b0, 1'b0, 2);

    // Round-robin with both requesters held back-to-back.
    phy_lat = 1;
    phy_xor = 16'h5A5A;
    push_a(1'b0, 21'h00_0100, 1'b1, 16'h0000, 1'b0, 1'b0, 1);
    push_a(1'b1, 21'h00_0201, 1'b0, 16'h1111, 1'b1, 1'b0, 1);
    push_a(1'b0, 21'h00_0302, 1'b0, 16'h2222, 1'b0, 1'b0, 1);
    push_a(1'b1, 21'h00_0403, 1'b1, 16'h0000, 1'b1, 1'b0, 1);
    fork
      begin
        req_a(1'b0, 21'h00_0100, 1'b1, 16'h0000, 1'b0);
        req_a(1'b0, 21'h00_0302, 1'b0, 16'h2222, 1'b0);
      end
      begin
        req_a(1'b1, 21'h00_0201, 1'b0, 16'h1111, 1'b1);
        req_a(1'b1, 21'h00_0403, 1'b1, 16'h0000, 1'b1);
      end
    join

    // DRP write that the PHY never acknowledges, then a normal DRP read.
    phy_never = 1'b1;
    xact(1'b1, 21'h0F_0010, 1'b0, 16'hCAFE, 1'b1, 1'b1, 0);
    phy_never = 1'b0;
    xact(1'b1, 21'h0F_0011, 1'b1, 16'h0000, 1'b1, 1'b0, 0);

    // Wrong-direction ack ignored for both a read and a write.
    phy_wrong = 1'b1;
    xact(1'b0, 21'h00_7777, 1'b1, 16'h0000, 1'b0, 1'b0, 5);
    xact(1'b0, 21'h00_7778, 1'b0, 16'h3333, 1'b0, 1'b0, 4);
    phy_wrong = 1'b0;

    // rdack coincident with the timeout cycle: completion wins.
    xact(1'b1, 21'h12_3456, 1'b1, 16'h0000, 1'b0, 1'b0, int'(TO));

    // Stray acks while idle must not produce a response.
    @(posedge clk156);
    #1 stray = 1'b1;
    @(posedge clk156);
    #1 stray = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    xact(1'b1, 21'h00_0ABC, 1'b1, 16'h0000, 1'b0, 1'b0, 2);

    // Reset during WAIT of a req0 access (last grant = 0 before reset).
    phy_lat = 100;
    req0_addr = 21'h00_0155; req0_rnw = 1'b1; req0_wrdata = '0; req0_drp = 1'b0;
    req0_valid = 1'b1;
    repeat (5) @(posedge clk156);
    #1;
    check("pre_rst_in_wait", 32'(training_ipif_cs), 32'd1);
    reset = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk156);
    check_reset_vals("rst_mid");
    @(posedge clk156);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk156);
    #1;
    phy_lat = 1;
    push_a(1'b0, 21'h00_0501, 1'b1, 16'h0000, 1'b0, 1'b0, 1);
    push_a(1'b1, 21'h00_0602, 1'b1, 16'h0000, 1'b0, 1'b0, 1);
    fork
      req_a(1'b0, 21'h00_0501, 1'b1, 16'h0000, 1'b0);
      req_a(1'b1, 21'h00_0602, 1'b1, 16'h0000, 1'b0);
    join

    // Fixed priority: req0 served while held, req1 only after req0 drops.
    push_b(1'b0, 21'h00_0A01);
    push_b(1'b0, 21'h00_0A02);
    push_b(1'b0, 21'h00_0A03);
    push_b(1'b1, 21'h00_0B01);
    fork
      begin
        req_b(1'b0, 21'h00_0A01);
        req_b(1'b0, 21'h00_0A02);
        req_b(1'b0, 21'h00_0A03);
      end
      req_b(1'b1, 21'h00_0B01);
    join

    repeat (5) @(posedge clk156);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("fp_sb_drained", 32'(fq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
